// File: rtl/register_scoreboard.sv
// Issue-side hazard scoreboard: one busy bit per integer and float register,
// set on issue of a writer and cleared by any of four writeback buses.
module register_scoreboard #(
  parameter bit INT_ZERO_HARDWIRED = 1'b1,
  parameter int PENDING_W          = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_valid,
  input  logic [4:0]           issue_rs_addr,
  input  logic                 issue_rs_float,
  input  logic                 issue_rs_used,
  input  logic [4:0]           issue_rt_addr,
  input  logic                 issue_rt_float,
  input  logic                 issue_rt_used,
  input  logic [4:0]           issue_rd_addr,
  input  logic                 issue_rd_float,
  input  logic                 issue_writes,
  input  logic                 write_enable_misc,
  input  logic [4:0]           write_addr_misc,
  input  logic                 write_float_misc,
  input  logic                 write_enable_alu,
  input  logic [4:0]           write_addr_alu,
  input  logic                 write_float_alu,
  input  logic                 write_enable_mem,
  input  logic [4:0]           write_addr_mem,
  input  logic                 write_float_mem,
  input  logic                 write_enable_fpu,
  input  logic [4:0]           write_addr_fpu,
  input  logic                 write_float_fpu,
  output logic                 issue_stall,
  output logic                 issue_accept,
  output logic [PENDING_W-1:0] pending_count,
  output logic                 wb_orphan
);

  localparam int NUM_UNITS = 4;

  // Integer r0 is masked out of every vector when it is hardwired.
  localparam logic [31:0] INT_MASK = INT_ZERO_HARDWIRED ? 32'hFFFF_FFFE : 32'hFFFF_FFFF;

  logic [31:0]          busy_int_q, busy_int_d;
  logic [31:0]          busy_flt_q, busy_flt_d;
  logic                 wb_orphan_q, wb_orphan_d;
  logic [PENDING_W-1:0] pending_count_q, pending_count_d;

  logic [NUM_UNITS-1:0] wb_en;
  logic [NUM_UNITS-1:0] wb_flt;
  logic [4:0]           wb_addr [NUM_UNITS];
  logic [31:0]          wb_dec  [NUM_UNITS];

  logic [31:0] hit_int_raw, hit_flt_raw;
  logic [31:0] hit_int, hit_flt;
  logic [31:0] busy_int_view;
  logic [31:0] set_dec, set_int, set_flt;

  logic busy_rs, busy_rt, busy_rd;
  logic hit_rs, hit_rt, hit_rd;
  logic ready_rs, ready_rt;

  assign wb_en  = {write_enable_fpu, write_enable_mem, write_enable_alu, write_enable_misc};
  assign wb_flt = {write_float_fpu, write_float_mem, write_float_alu, write_float_misc};
  assign wb_addr[0] = write_addr_misc;
  assign wb_addr[1] = write_addr_alu;
  assign wb_addr[2] = write_addr_mem;
  assign wb_addr[3] = write_addr_fpu;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_UNITS; gi++) begin : g_wb_dec
      assign wb_dec[gi] = wb_en[gi] ? (32'd1 << wb_addr[gi]) : 32'd0;
    end
  endgenerate

  // Merge the per-unit one-hot decodes; duplicate writers collapse to one hit.
  always_comb begin
    hit_int_raw = 32'd0;
    hit_flt_raw = 32'd0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (wb_flt[u]) hit_flt_raw = hit_flt_raw | wb_dec[u];
      else           hit_int_raw = hit_int_raw | wb_dec[u];
    end
  end

  assign hit_int       = hit_int_raw & INT_MASK;
  assign hit_flt       = hit_flt_raw;
  assign busy_int_view = busy_int_q & INT_MASK;

  function automatic logic pick(input logic [31:0] vec_int, input logic [31:0] vec_flt,
                                input logic [4:0] addr, input logic flt);
    pick = flt ? vec_flt[addr] : vec_int[addr];
  endfunction

  assign busy_rs = pick(busy_int_view, busy_flt_q, issue_rs_addr, issue_rs_float);
  assign busy_rt = pick(busy_int_view, busy_flt_q, issue_rt_addr, issue_rt_float);
  assign busy_rd = pick(busy_int_view, busy_flt_q, issue_rd_addr, issue_rd_float);
  assign hit_rs  = pick(hit_int, hit_flt, issue_rs_addr, issue_rs_float);
  assign hit_rt  = pick(hit_int, hit_flt, issue_rt_addr, issue_rt_float);
  assign hit_rd  = pick(hit_int, hit_flt, issue_rd_addr, issue_rd_float);

  // A writeback in the same cycle counts as ready: the forwarding chain bypasses it.
  assign ready_rs = ~busy_rs | hit_rs;
  assign ready_rt = ~busy_rt | hit_rt;

  assign issue_stall = issue_valid & ((issue_rs_used & ~ready_rs) |
                                      (issue_rt_used & ~ready_rt) |
                                      (issue_writes & busy_rd & ~hit_rd));
  assign issue_accept = issue_valid & ~issue_stall;

  assign set_dec = (issue_accept & issue_writes) ? (32'd1 << issue_rd_addr) : 32'd0;
  assign set_int = issue_rd_float ? 32'd0 : (set_dec & INT_MASK);
  assign set_flt = issue_rd_float ? set_dec : 32'd0;

  function automatic logic [PENDING_W-1:0] popcount64(input logic [63:0] v);
    logic [PENDING_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < 64; i++) begin
      cnt = cnt + PENDING_W'(v[i]);
    end
    return cnt;
  endfunction

  // Clear first, then set, so an issuing writer wins over a same-cycle writeback.
  always_comb begin
    busy_int_d      = (busy_int_q & ~hit_int) | set_int;
    busy_flt_d      = (busy_flt_q & ~hit_flt) | set_flt;
    wb_orphan_d     = wb_orphan_q | (|(hit_int & ~busy_int_view)) | (|(hit_flt & ~busy_flt_q));
    pending_count_d = popcount64({busy_int_d, busy_flt_d});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_int_q      <= 32'd0;
      busy_flt_q      <= 32'd0;
      wb_orphan_q     <= 1'b0;
      pending_count_q <= '0;
    end else begin
      busy_int_q      <= busy_int_d;
      busy_flt_q      <= busy_flt_d;
      wb_orphan_q     <= wb_orphan_d;
      pending_count_q <= pending_count_d;
    end
  end

  assign pending_count = pending_count_q;
  assign wb_orphan     = wb_orphan_q;

endmodule

// File: tb/tb_register_scoreboard.sv
// Directed bench for register_scoreboard: stall/accept, writeback bypass,
// WAW, r0 hardwiring, orphan flag and reset.
module tb_register_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic       issue_valid;
  logic [4:0] issue_rs_addr, issue_rt_addr, issue_rd_addr;
  logic       issue_rs_float, issue_rt_float, issue_rd_float;
  logic       issue_rs_used, issue_rt_used, issue_writes;
  logic       we_misc, we_alu, we_mem, we_fpu;
  logic [4:0] wa_misc, wa_alu, wa_mem, wa_fpu;
  logic       wf_misc, wf_alu, wf_mem, wf_fpu;
  logic       issue_stall, issue_accept, wb_orphan;
  logic [6:0] pending_count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  register_scoreboard #(.INT_ZERO_HARDWIRED(1'b1), .PENDING_W(7)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid),
    .issue_rs_addr(issue_rs_addr), .issue_rs_float(issue_rs_float), .issue_rs_used(issue_rs_used),
    .issue_rt_addr(issue_rt_addr), .issue_rt_float(issue_rt_float), .issue_rt_used(issue_rt_used),
    .issue_rd_addr(issue_rd_addr), .issue_rd_float(issue_rd_float), .issue_writes(issue_writes),
    .write_enable_misc(we_misc), .write_addr_misc(wa_misc), .write_float_misc(wf_misc),
    .write_enable_alu(we_alu),   .write_addr_alu(wa_alu),   .write_float_alu(wf_alu),
    .write_enable_mem(we_mem),   .write_addr_mem(wa_mem),   .write_float_mem(wf_mem),
    .write_enable_fpu(we_fpu),   .write_addr_fpu(wa_fpu),   .write_float_fpu(wf_fpu),
    .issue_stall(issue_stall), .issue_accept(issue_accept),
    .pending_count(pending_count), .wb_orphan(wb_orphan)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    else begin
      n_pass++;
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic idle();
    issue_valid = 0; issue_writes = 0;
    issue_rs_used = 0; issue_rt_used = 0;
    issue_rs_addr = 0; issue_rt_addr = 0; issue_rd_addr = 0;
    issue_rs_float = 0; issue_rt_float = 0; issue_rd_float = 0;
    we_misc = 0; we_alu = 0; we_mem = 0; we_fpu = 0;
    wa_misc = 0; wa_alu = 0; wa_mem = 0; wa_fpu = 0;
    wf_misc = 0; wf_alu = 0; wf_mem = 0; wf_fpu = 0;
  endtask

  // Advance one cycle: inputs held so far are committed at the posedge.
  task automatic cyc();
    @(negedge clk);
    idle();
  endtask

  task automatic issue_write(input logic [4:0] a, input logic f);
    cyc();
    issue_valid = 1; issue_writes = 1; issue_rd_addr = a; issue_rd_float = f;
    #1;
  endtask

  // Read-only issue has no side effect, so it doubles as a busy probe.
  task automatic probe(input string tag, input logic [4:0] a, input logic f, input logic exp);
    cyc();
    issue_valid = 1; issue_rs_used = 1; issue_rs_addr = a; issue_rs_float = f;
    #1;
    check(tag, 32'(issue_stall), 32'(exp));
  endtask

  initial begin
    idle();
    reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    #1;
    check("reset pending", 32'(pending_count), 0);
    check("reset orphan", 32'(wb_orphan), 0);
    cyc();
    issue_valid = 1; issue_rs_used = 1; issue_rs_addr = 5;
    #1;
    check("reset stall", 32'(issue_stall), 0);
    check("reset accept", 32'(issue_accept), 1);

    // 1: write int r3
    issue_write(5'd3, 1'b0);
    check("t1 accept", 32'(issue_accept), 1);
    cyc(); #1;
    check("t1 pending", 32'(pending_count), 1);
    probe("t1 r3 busy", 5'd3, 1'b0, 1'b1);

    // 2: bypass from alu writeback
    cyc();
    issue_valid = 1; issue_rs_used = 1; issue_rs_addr = 3;
    #1;
    check("t2 stall nowb", 32'(issue_stall), 1);
    check("t2 accept nowb", 32'(issue_accept), 0);
    we_alu = 1; wa_alu = 3; wf_alu = 0;
    #1;
    check("t2 stall bypass", 32'(issue_stall), 0);
    check("t2 accept bypass", 32'(issue_accept), 1);
    cyc(); #1;
    check("t2 pending", 32'(pending_count), 0);
    check("t2 orphan", 32'(wb_orphan), 0);
    probe("t2 r3 idle", 5'd3, 1'b0, 1'b0);

    // 3: float r3 independent of int r3; rt path
    issue_write(5'd3, 1'b1);
    cyc(); #1;
    check("t3 pending", 32'(pending_count), 1);
    probe("t3 int r3", 5'd3, 1'b0, 1'b0);
    cyc();
    issue_valid = 1; issue_rt_used = 1; issue_rt_addr = 3; issue_rt_float = 1;
    #1;
    check("t3 flt r3 rt", 32'(issue_stall), 1);
    issue_rt_used = 0;
    #1;
    check("t3 rt unused", 32'(issue_stall), 0);
    cyc();
    we_fpu = 1; wa_fpu = 3; wf_fpu = 1;
    cyc(); #1;
    check("t3 cleared", 32'(pending_count), 0);

    // 4: issue write r7 races fpu writeback of r7; set wins
    issue_write(5'd7, 1'b0);
    cyc(); #1;
    check("t4 pending pre", 32'(pending_count), 1);
    issue_write(5'd7, 1'b0);
    check("t4 waw stall", 32'(issue_stall), 1);
    we_fpu = 1; wa_fpu = 7; wf_fpu = 0;
    #1;
    check("t4 accept", 32'(issue_accept), 1);
    cyc(); #1;
    check("t4 pending", 32'(pending_count), 1);
    check("t4 orphan", 32'(wb_orphan), 0);
    probe("t4 r7 busy", 5'd7, 1'b0, 1'b1);

    // 5: WAW on r4, no stall when not valid, two units clearing one register
    issue_write(5'd4, 1'b0);
    cyc(); #1;
    check("t5 pending 2", 32'(pending_count), 2);
    issue_write(5'd4, 1'b0);
    check("t5 waw stall", 32'(issue_stall), 1);
    check("t5 waw accept", 32'(issue_accept), 0);
    issue_valid = 0;
    #1;
    check("t5 invalid stall", 32'(issue_stall), 0);
    cyc();
    we_misc = 1; wa_misc = 4; we_alu = 1; wa_alu = 4; we_mem = 1; wa_mem = 7;
    cyc(); #1;
    check("t5 dual clear", 32'(pending_count), 0);
    check("t5 dual orphan", 32'(wb_orphan), 0);
    issue_write(5'd0, 1'b0);
    check("t5 r0 accept", 32'(issue_accept), 1);
    cyc(); #1;
    check("t5 r0 pending", 32'(pending_count), 0);
    probe("t5 r0 idle", 5'd0, 1'b0, 1'b0);

    // 6: orphan writeback, then reset with 5 busy
    cyc();
    we_mem = 1; wa_mem = 9; wf_mem = 1;
    cyc(); #1;
    check("t6 orphan set", 32'(wb_orphan), 1);
    check("t6 orphan pend", 32'(pending_count), 0);
    issue_write(5'd1, 1'b0);
    issue_write(5'd2, 1'b0);
    issue_write(5'd5, 1'b0);
    issue_write(5'd5, 1'b1);
    issue_write(5'd31, 1'b1);
    cyc(); #1;
    check("t6 pending 5", 32'(pending_count), 5);
    check("t6 orphan held", 32'(wb_orphan), 1);
    reset = 1;
    cyc();
    reset = 0;
    #1;
    check("t6 reset pending", 32'(pending_count), 0);
    check("t6 reset orphan", 32'(wb_orphan), 0);
    probe("t6 r1 idle", 5'd1, 1'b0, 1'b0);
    probe("t6 f31 idle", 5'd31, 1'b1, 1'b0);

    cyc();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
